// File: rtl/oled_ctrl_i2c.sv
// oled_ctrl_i2c: I2C master that streams a ROM command table or a solid/interlaced
// fill pattern to an SSD1306-class OLED, one 3-byte write transaction per byte.
module oled_ctrl_i2c #(
    parameter logic [6:0] OLED_CHIP_ADDR = 7'h3C,
    parameter int         CONFIG_LEN     = 32,
    parameter int         SCL_QUARTER    = 32,
    parameter int         FILL_BYTES     = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oen,
    output logic       scl_out,
    output logic       scl_oen,
    output logic       busy,
    output logic       done,
    output logic       config_reg_read_en,
    output logic [4:0] config_reg_addr,
    input  logic [7:0] config_reg_data,
    input  logic       init,
    input  logic       all_black_disp,
    input  logic       all_white_disp,
    input  logic       interlace_disp
);
    typedef enum logic [3:0] {IDLE, ROM_RD, ROM_WAIT, START, TX_BYTE, ACK, STOP, GAP, NEXT} state_t;
    localparam int CW = $clog2(SCL_QUARTER + 1);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] ph_q, ph_d, byte_q, byte_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d, pat_q, pat_d;
    logic [15:0] idx_q, idx_d, total;
    logic [4:0] addr_q, addr_d;
    logic cfg_q, cfg_d, nack_q, nack_d, rd_q, rd_d;
    logic sda_oen_q, sda_oen_d, scl_oen_q, scl_oen_d, busy_q, busy_d, done_q, done_d;
    logic stall, tick;
    // A released SCL still read low means the slave is stretching; freeze the phase timer.
    assign stall = scl_oen_q && !scl_in;
    assign tick  = !stall && cnt_q == CW'(SCL_QUARTER - 1);
    assign total = cfg_q ? 16'(CONFIG_LEN) : 16'(FILL_BYTES);
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        cfg_d   = cfg_q;
        nack_d  = nack_q;
        done_d  = 1'b0;
        cnt_d   = '0;
        ph_d    = '0;
        if (state_q inside {START, TX_BYTE, ACK, STOP, GAP}) begin
            cnt_d = tick ? '0 : stall ? cnt_q : cnt_q + 1'b1;
            ph_d  = tick ? ph_q + 1'b1 : ph_q;
        end
        case (state_q)
            IDLE: if (init || all_black_disp || all_white_disp || interlace_disp) begin
                cfg_d   = init;
                idx_d   = '0;
                nack_d  = 1'b0;
                pat_d   = all_black_disp ? 8'h00 : all_white_disp ? 8'hFF : 8'h55;
                state_d = init ? ROM_RD : START;
            end
            ROM_RD: state_d = ROM_WAIT;
            ROM_WAIT: begin
                pat_d   = config_reg_data;
                state_d = START;
            end
            START: if (tick && ph_q == 2'd2) begin
                state_d = TX_BYTE;
                ph_d    = '0;
                byte_d  = '0;
                bit_d   = '0;
                sh_d    = {OLED_CHIP_ADDR, 1'b0};
            end
            TX_BYTE: if (tick && ph_q == 2'd3) begin
                bit_d   = bit_q + 1'b1;
                sh_d    = {sh_q[6:0], 1'b0};
                state_d = bit_q == 3'd7 ? ACK : TX_BYTE;
            end
            ACK: begin
                if (tick && ph_q == 2'd2) nack_d = sda_in;
                if (tick && ph_q == 2'd3) begin
                    state_d = (nack_q || byte_q == 2'd2) ? STOP : TX_BYTE;
                    byte_d  = byte_q + 1'b1;
                    sh_d    = byte_q == 2'd0 ? (cfg_q ? 8'h00 : 8'h40) : pat_q;
                end
            end
            STOP: if (tick && ph_q == 2'd2) begin
                state_d = nack_q ? IDLE : GAP;
                ph_d    = '0;
            end
            GAP: if (tick && ph_q == 2'd3) state_d = NEXT;
            NEXT: begin
                idx_d   = idx_q + 1'b1;
                done_d  = idx_q == total - 16'd1;
                state_d = done_d ? IDLE : cfg_q ? ROM_RD : START;
            end
            default: state_d = IDLE;
        endcase
        rd_d      = state_d == ROM_RD;
        addr_d    = state_d == ROM_RD ? idx_d[4:0] : addr_q;
        busy_d    = state_d != IDLE || done_d;
        sda_oen_d = state_d == TX_BYTE ? sh_d[7] : state_d == START ? ph_d == 2'd0 :
                    state_d == STOP ? ph_d == 2'd2 : 1'b1;
        scl_oen_d = state_d inside {TX_BYTE, ACK} ? ph_d inside {2'd1, 2'd2} :
                    state_d == START ? ph_d != 2'd2 : state_d == STOP ? ph_d != 2'd0 : 1'b1;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ph_q      <= '0;
            byte_q    <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            pat_q     <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            cfg_q     <= 1'b0;
            nack_q    <= 1'b0;
            rd_q      <= 1'b0;
            sda_oen_q <= 1'b1;
            scl_oen_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ph_q      <= ph_d;
            byte_q    <= byte_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            pat_q     <= pat_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            cfg_q     <= cfg_d;
            nack_q    <= nack_d;
            rd_q      <= rd_d;
            sda_oen_q <= sda_oen_d;
            scl_oen_q <= scl_oen_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
    assign sda_out            = 1'b0;
    assign scl_out            = 1'b0;
    assign sda_oen            = sda_oen_q;
    assign scl_oen            = scl_oen_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign config_reg_read_en = rd_q;
    assign config_reg_addr    = addr_q;
endmodule

// File: tb/tb_oled_ctrl_i2c.sv
// tb_oled_ctrl_i2c: directed bench with an I2C slave model, a latency-1 ROM and open-drain wiring.
module tb_oled_ctrl_i2c;
    localparam int Q = 2, CL = 32, FB = 16;
    logic clk = 1'b0, rst = 1'b0;
    logic sda_out, sda_oen, scl_out, scl_oen, busy, done, rd_en;
    logic [4:0] rd_addr;
    logic [7:0] rom_data = 8'h00;
    logic init = 1'b0, blk = 1'b0, wht = 1'b0, ilc = 1'b0;
    logic slave_sda_low = 1'b0, slave_scl_hold = 1'b0;
    logic scl_line, sda_line;
    logic [6:0] slave_addr = 7'h3C;
    bit stretch_en = 1'b0, clr = 1'b0;
    int passed = 0, total = 0;
    int bitc, bytec, starts, stops, nacks, done_cnt, done_nobusy, rd_cnt, stretch_cnt, hi;
    int min_hi = 1000000;
    bit ign;
    logic [7:0] sh, ba, br, bd;
    logic scl_p = 1'b1, sda_p = 1'b1;
    logic [7:0] log_a[$], log_r[$], log_d[$];

    assign scl_line = scl_oen & ~slave_scl_hold;
    assign sda_line = sda_oen & ~slave_sda_low;

    oled_ctrl_i2c #(.OLED_CHIP_ADDR(7'h3C), .CONFIG_LEN(CL), .SCL_QUARTER(Q), .FILL_BYTES(FB)) dut (
        .clk(clk), .reset(rst), .scl_in(scl_line), .sda_in(sda_line),
        .sda_out(sda_out), .sda_oen(sda_oen), .scl_out(scl_out), .scl_oen(scl_oen),
        .busy(busy), .done(done), .config_reg_read_en(rd_en), .config_reg_addr(rd_addr),
        .config_reg_data(rom_data), .init(init), .all_black_disp(blk),
        .all_white_disp(wht), .interlace_disp(ilc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rom_data <= 8'h80 + {3'b000, rd_addr};

    // Slave at slave_addr: decodes START/STOP/bits on the wires, ACKs, optionally stretches SCL.
    always @(negedge clk) begin
        if (rst || clr) begin
            bitc = 0; bytec = 0; ign = 1'b0; slave_sda_low = 1'b0; stretch_cnt = 0; slave_scl_hold = 1'b0;
            starts = 0; stops = 0; nacks = 0; done_cnt = 0; done_nobusy = 0; rd_cnt = 0;
            min_hi = 1000000; hi = 0;
            log_a.delete(); log_r.delete(); log_d.delete();
        end else begin
            if (done) begin
                done_cnt++;
                if (!busy) done_nobusy++;
            end
            if (rd_en) rd_cnt++;
            if (scl_p && scl_line && sda_p && !sda_line) begin
                starts++; bitc = 0; bytec = 0; ign = 1'b0;
            end else if (scl_p && scl_line && !sda_p && sda_line) begin
                stops++;
                if (bytec == 3) begin
                    log_a.push_back(ba); log_r.push_back(br); log_d.push_back(bd);
                end
                bytec = 0;
            end else if (!scl_p && scl_line) begin
                if (!ign && bitc < 8) begin
                    sh = {sh[6:0], sda_line};
                    bitc++;
                end
            end else if (scl_p && !scl_line) begin
                if (hi < min_hi) min_hi = hi;
                if (!ign && bitc == 8) begin
                    if (bytec != 0 || sh[7:1] == slave_addr) begin
                        slave_sda_low = 1'b1;
                        if (bytec == 0) ba = sh; else if (bytec == 1) br = sh; else bd = sh;
                    end else begin
                        ign = 1'b1;
                        nacks++;
                    end
                    bitc = 9;
                end else if (!ign && bitc == 9) begin
                    slave_sda_low = 1'b0;
                    bitc = 0;
                    bytec++;
                    if (stretch_en) stretch_cnt = 200;
                end
            end
            hi = scl_line ? hi + 1 : 0;
            if (stretch_cnt > 0) stretch_cnt--;
            slave_scl_hold = stretch_cnt > 0;
        end
        scl_p = scl_line;
        sda_p = sda_line;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear();
        @(posedge clk) clr = 1'b1;
        @(posedge clk) clr = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] m);
        @(negedge clk) {init, blk, wht, ilc} = m;
        @(negedge clk) {init, blk, wht, ilc} = 4'b0000;
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, busy}, 32'd0);
    endtask

    task automatic check_log(input string tag, input int n, input logic [7:0] reg_e, input bit cfg, input logic [7:0] pat);
        int bad = 0;
        check({tag, "_count"}, log_d.size(), n);
        for (int i = 0; i < log_d.size(); i++)
            if (log_a[i] !== 8'h78 || log_r[i] !== reg_e || log_d[i] !== (cfg ? 8'h80 + 8'(i) : pat)) bad++;
        check({tag, "_bad_writes"}, bad, 0);
        if (log_d.size() > 0) check({tag, "_last_data"}, log_d[log_d.size() - 1], cfg ? 8'h80 + 8'(n - 1) : pat);
    endtask

    initial begin
        int n;
        #3 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_sda_oen", sda_oen, 1);
        check("rst_scl_oen", scl_oen, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_pad_out", {sda_out, scl_out}, 0);
        @(negedge clk) rst = 1'b0;

        clear();
        pulse(4'b1000);
        check("cfg_busy_on", busy, 1);
        wait_idle(20000, "cfg_idle");
        check_log("cfg", CL, 8'h00, 1'b1, 8'h00);
        check("cfg_addr0", log_a.size() > 0 ? log_a[0] : 8'h00, 8'h78);
        check("cfg_done", done_cnt, 1);
        check("cfg_done_busy", done_nobusy, 0);
        check("cfg_rom_reads", rd_cnt, CL);
        check("cfg_scl_high", min_hi >= Q, 1);

        slave_addr = 7'h3D;
        clear();
        pulse(4'b1000);
        wait_idle(240, "nack_idle");
        check("nack_count", nacks, 1);
        check("nack_starts", starts, 1);
        check("nack_stops", stops, 1);
        check("nack_done", done_cnt, 0);
        check("nack_writes", log_d.size(), 0);
        repeat (300) @(negedge clk);
        check("nack_no_restart", starts, 1);
        check("nack_busy", busy, 0);
        slave_addr = 7'h3C;

        clear();
        pulse(4'b0010);
        wait_idle(6000, "white_idle");
        check_log("white", FB, 8'h40, 1'b0, 8'hFF);
        check("white_rom_reads", rd_cnt, 0);
        check("white_done", done_cnt, 1);

        clear();
        pulse(4'b0001);
        wait_idle(6000, "ilace_idle");
        check_log("ilace", FB, 8'h40, 1'b0, 8'h55);
        check("ilace_rom_reads", rd_cnt, 0);

        clear();
        pulse(4'b0100);
        wait_idle(6000, "black_idle");
        check_log("black", FB, 8'h40, 1'b0, 8'h00);

        clear();
        pulse(4'b1100);
        repeat (1000) @(negedge clk);
        pulse(4'b1000);
        wait_idle(20000, "prio_idle");
        check_log("prio", CL, 8'h00, 1'b1, 8'h00);
        check("prio_done", done_cnt, 1);
        check("prio_rom_reads", rd_cnt, CL);

        clear();
        pulse(4'b1000);
        n = 0;
        while (!(bytec == 2 && bitc == 3) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("arst_reached_data", n < 2000, 1);
        rst = 1'b1;
        #1;
        check("arst_sda_oen", sda_oen, 1);
        check("arst_scl_oen", scl_oen, 1);
        check("arst_busy", busy, 0);
        check("arst_rd_en", rd_en, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear();
        pulse(4'b1000);
        wait_idle(20000, "arst_idle");
        check_log("arst_fresh", CL, 8'h00, 1'b1, 8'h00);
        check("arst_done", done_cnt, 1);

        stretch_en = 1'b1;
        clear();
        pulse(4'b1000);
        wait_idle(40000, "str_idle");
        check_log("str", CL, 8'h00, 1'b1, 8'h00);
        check("str_scl_high", min_hi >= Q, 1);
        check("str_done", done_cnt, 1);
        stretch_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
